// File: rtl/vrf_masked_mp.sv
// Vector register file with masked multi-port writes.
//
// Purpose:
//   Holds els_p vector registers of vlen_p elements x vdw_p bits. Any number
//   of write ports may target the same register in one cycle. Each element
//   is taken from the lowest-index port whose mask enables it. Reads are
//   registered, with an optional write-to-read bypass. A per-register busy
//   scoreboard tracks reservations and releases for the lane sequencers.
//
// Ports:
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   r_v_i / r_addr_i       per-port read request and register address
//   r_v_o / r_data_o       read valid and data, one cycle after the request
//   w_v_i / w_addr_i       per-port write request and register address
//   w_data_i / w_mask_i    write data and per-element write enable
//   w_release_i            the write also clears the busy bit of w_addr_i
//   w_conflict_o           pulse: a masked element of the port lost arbitration
//   rsv_v_i / rsv_addr_i   reserve a register (set its busy bit)
//   rsv_err_o              pulse: the reservation hit a register that stays busy
//   busy_o                 per-register busy scoreboard
module vrf_masked_mp #(
    parameter  int els_p         = 32,
    parameter  int vlen_p        = 8,
    parameter  int vdw_p         = 32,
    parameter  int r_ports_p     = 4,
    parameter  int w_ports_p     = 4,
    parameter  int bypass_p      = 1,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int data_width_lp = vlen_p * vdw_p
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [r_ports_p-1:0]                        r_v_i,
    input  logic [r_ports_p-1:0][addr_width_lp-1:0]     r_addr_i,
    output logic [r_ports_p-1:0]                        r_v_o,
    output logic [r_ports_p-1:0][data_width_lp-1:0]     r_data_o,
    input  logic [w_ports_p-1:0]                        w_v_i,
    input  logic [w_ports_p-1:0][addr_width_lp-1:0]     w_addr_i,
    input  logic [w_ports_p-1:0][data_width_lp-1:0]     w_data_i,
    input  logic [w_ports_p-1:0][vlen_p-1:0]            w_mask_i,
    input  logic [w_ports_p-1:0]                        w_release_i,
    output logic [w_ports_p-1:0]                        w_conflict_o,
    input  logic                                        rsv_v_i,
    input  logic [addr_width_lp-1:0]                    rsv_addr_i,
    output logic                                        rsv_err_o,
    output logic [els_p-1:0]                            busy_o
);

    localparam logic [addr_width_lp:0] els_ext_lp = (addr_width_lp + 1)'(els_p);

    // Only matters when els_p is not a power of two.
    function automatic logic in_range(input logic [addr_width_lp-1:0] a);
        return ({1'b0, a} < els_ext_lp);
    endfunction

    logic [data_width_lp-1:0]                    r_mem [els_p];
    logic [els_p-1:0]                            r_busy;
    logic [r_ports_p-1:0]                        r_rv;
    logic [r_ports_p-1:0][data_width_lp-1:0]     r_rdata;
    logic [w_ports_p-1:0]                        r_conflict;
    logic                                        r_rsv_err;

    logic [data_width_lp-1:0]                    w_mem_next [els_p];
    logic [w_ports_p-1:0]                        w_wen;
    logic [w_ports_p-1:0]                        w_conflict_next;
    logic [r_ports_p-1:0][data_width_lp-1:0]     w_rd;
    logic [els_p-1:0]                            w_set;
    logic [els_p-1:0]                            w_clr;
    logic [els_p-1:0]                            w_busy_next;
    logic                                        w_rsv_err_next;

    always_comb begin
        w_wen = '0;
        for (int p = 0; p < w_ports_p; p++) begin
            w_wen[p] = w_v_i[p] & in_range(w_addr_i[p]);
        end
    end

    // Merge writes from the highest port down so the lowest-index port is
    // applied last and wins each element it masks.
    always_comb begin
        w_mem_next = r_mem;
        for (int p = w_ports_p - 1; p >= 0; p--) begin
            if (w_wen[p]) begin
                for (int e = 0; e < vlen_p; e++) begin
                    if (w_mask_i[p][e]) begin
                        w_mem_next[w_addr_i[p]][e*vdw_p +: vdw_p] = w_data_i[p][e*vdw_p +: vdw_p];
                    end
                end
            end
        end
    end

    always_comb begin
        w_conflict_next = '0;
        for (int q = 1; q < w_ports_p; q++) begin
            for (int p = 0; p < q; p++) begin
                if (w_wen[p] && w_wen[q] && (w_addr_i[p] == w_addr_i[q]) &&
                    (|(w_mask_i[p] & w_mask_i[q]))) begin
                    w_conflict_next[q] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < r_ports_p; i++) begin
            if (in_range(r_addr_i[i])) begin
                w_rd[i] = (bypass_p != 0) ? w_mem_next[r_addr_i[i]] : r_mem[r_addr_i[i]];
            end
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 0; r < els_p; r++) begin
            w_set[r] = rsv_v_i && (rsv_addr_i == addr_width_lp'(r));
            for (int p = 0; p < w_ports_p; p++) begin
                if (w_v_i[p] && w_release_i[p] && (w_addr_i[p] == addr_width_lp'(r))) begin
                    w_clr[r] = 1'b1;
                end
            end
        end
    end

    // A reservation wins over a release of the same register in the same cycle.
    always_comb begin
        w_busy_next    = w_set | (r_busy & ~w_clr);
        w_rsv_err_next = 1'b0;
        if (rsv_v_i && in_range(rsv_addr_i)) begin
            w_rsv_err_next = r_busy[rsv_addr_i] & ~w_clr[rsv_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < els_p; r++) begin
                r_mem[r] <= '0;
            end
            r_busy     <= '0;
            r_rv       <= '0;
            r_rdata    <= '0;
            r_conflict <= '0;
            r_rsv_err  <= 1'b0;
        end else begin
            r_mem      <= w_mem_next;
            r_busy     <= w_busy_next;
            r_rv       <= r_v_i;
            r_conflict <= w_conflict_next;
            r_rsv_err  <= w_rsv_err_next;
            for (int i = 0; i < r_ports_p; i++) begin
                if (r_v_i[i]) begin
                    r_rdata[i] <= w_rd[i];
                end
            end
        end
    end

    assign r_v_o        = r_rv;
    assign r_data_o     = r_rdata;
    assign w_conflict_o = r_conflict;
    assign rsv_err_o    = r_rsv_err;
    assign busy_o       = r_busy;

endmodule

// File: doc/vrf_masked_mp.md
Name: vrf_masked_mp

Overview:
Next-generation vector register file for the vector unit. It has independent, parametrised counts of read and write ports, and each write port carries a per-element write mask. Reads are registered, with an optional write-to-read bypass. Same-register write collisions are arbitrated per element, and a per-register busy scoreboard lets the lane sequencers track in-flight writers.

Parameters:
els_p, 32, number of vector registers
vlen_p, 8, elements per vector
vdw_p, 32, bits per element
r_ports_p, 4, number of read ports
w_ports_p, 4, number of write ports
bypass_p, 1, 1 = a read returns data merged with same-cycle writes; 0 = a read returns the pre-write value
addr_width_lp (local), BSG_SAFE_CLOG2(els_p), register address width
data_width_lp (local), vlen_p*vdw_p, width of one vector

Ports:
clk_i  in  1  clock; the single clock for all state
reset_n_i  in  1  asynchronous, active-low reset
r_v_i  in  r_ports_p  per-port read request
r_addr_i  in  r_ports_p x addr_width_lp  read register address
r_v_o  out  r_ports_p  read data valid, one cycle after the request
r_data_o  out  r_ports_p x data_width_lp  registered read data
w_v_i  in  w_ports_p  per-port write request
w_addr_i  in  w_ports_p x addr_width_lp  write register address
w_data_i  in  w_ports_p x data_width_lp  write data
w_mask_i  in  w_ports_p x vlen_p  per-element write enable
w_release_i  in  w_ports_p  this write clears the busy bit of w_addr_i
w_conflict_o  out  w_ports_p  registered pulse: at least one masked element of this port lost arbitration
rsv_v_i  in  1  reserve a register (mark it busy)
rsv_addr_i  in  addr_width_lp  register to reserve
rsv_err_o  out  1  registered pulse: the reservation targeted a register that stays busy
busy_o  out  els_p  registered per-register busy scoreboard

Behaviour:
- Reset (reset_n_i=0, asynchronous): all register contents, r_v_o, r_data_o, w_conflict_o, busy_o and rsv_err_o go to 0 immediately. Reset asserted mid-operation discards any write in that cycle. The first write is accepted on the first rising edge after deassertion.
- Write commit: at posedge, for each register and each element e, the element takes w_data_i[p][e] from the lowest-index port p with w_v_i[p], w_addr_i[p]==reg and w_mask_i[p][e] all true.
- Elements with no winning port keep their value.
- w_v_i with an all-zero mask is legal and writes nothing; a release on that write still applies.
- w_conflict_o[q] is 1 in cycle t+1 iff, in cycle t, port q had a masked element that was also masked by a lower-index port to the same address. Otherwise it is 0. Port 0 never conflicts.
- Read, latency 1: r_v_o[i]=r_v_i[i] delayed one cycle. When r_v_i[i]=1, r_data_o[i] is loaded with the contents of r_addr_i[i].
  - bypass_p=1: the loaded value is the post-commit (merged) value of that cycle.
  - bypass_p=0: the loaded value is the pre-commit value.
- When r_v_i[i]=0, r_data_o[i] holds its previous value.
- Out-of-range addresses (address >= els_p, non-power-of-2 els_p):
  - writes are ignored;
  - reads return 0;
  - reservations are ignored and do not raise rsv_err_o.
- Scoreboard, per register at posedge:
  - set = rsv_v_i and rsv_addr_i==reg.
  - clr = any port with w_v_i, w_release_i and w_addr_i==reg.
  - busy_next = set | (busy & ~clr); set wins over a simultaneous clear.
- rsv_err_o in cycle t+1 = rsv_v_i & busy[rsv_addr_i] & ~clr[rsv_addr_i] in cycle t. The register remains busy after an error.
- Writes are never blocked by busy state; the scoreboard is advisory for the sequencers.
- No combinational path from any input to any output; all outputs are flop outputs.

Test Plan:
- Reset, then w0 writes reg 3 = {8{32'hA5A5_0000+e}} with mask 8'hFF; read reg 3 next cycle -> r_v_o=1 the cycle after, data matches all 8 elements; other regs read 0.
- Reg 5 preloaded 0 and read in the cycle of a write from w0 (mask 8'h0F, data all 1s) -> bypass_p=1: elements 0-3 all 1s, 4-7 zero; bypass_p=0: all zero, and the following read shows the merged value.
- Same cycle, reg 7 with full-vector writes of data 8'h11.. from w0 (mask 8'hF0), 8'h22.. from w1 (mask 8'h3C), 8'h33.. from w2 (mask 8'h03):
  - elements 4-7 take w0 data, 2-3 take w1 data, 0-1 take w2 data;
  - w_conflict_o=4'b0010 next cycle.
- Reserve reg 9 -> busy_o[9]=1 next cycle. Reserve 9 again -> rsv_err_o pulses one cycle. A write to 9 with w_release_i=1 -> busy_o[9]=0. Reserving 9 while simultaneously releasing it -> busy stays 1 and rsv_err_o=0.
- Pulse reset_n_i low asynchronously between clock edges while writes are streaming -> outputs 0 without waiting for an edge; the write in flight is lost; the stream resumes correctly after deassertion.
- Random regression: 10k cycles of random reads, writes, masks, reservations and releases, checked against a reference model, for both bypass_p settings and for r_ports_p=2/w_ports_p=3.
